// File: rtl/ahb_lite_arbiter.sv
// Two-requester round-robin front end driving one AHB-Lite master port.
// Optional wait-state watchdog enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_lite_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RW        = 2,
  parameter int TO_CYCLES = 16
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [1:0]      req,
  input  logic [2*AW-1:0] req_addr,
  input  logic [1:0]      req_write,
  input  logic [5:0]      req_size,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      ack,
  output logic            ack_err,
  output logic [DW-1:0]   ack_rdata,
  output logic [1:0]      gnt,
  output logic            timeout,
  output logic            hsel,
  output logic [AW-1:0]   haddr,
  output logic [1:0]      htrans,
  output logic            hwrite,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic [3:0]      hprot,
  output logic [DW-1:0]   hwdata,
  input  logic [DW-1:0]   hrdata,
  input  logic            hready,
  input  logic [RW-1:0]   hresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [2:0] MAXSZ = 3'($clog2(DW/8));

  state_t        state, state_n;
  logic          last, last_n;
  logic          own, own_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic [1:0]    ack_n, gnt_n, htrans_n;
  logic          ack_err_n, hsel_n, hwrite_n;
  logic [DW-1:0] rdata_n, hwdata_n;
  logic [AW-1:0] haddr_n, amask;
  logic [2:0]    hsize_n;

  logic [1:0]    cand, win_oh, own_oh;
  logic          win, misalign;
  logic [AW-1:0] win_addr;
  logic [2:0]    win_size;
  logic [DW-1:0] win_wdata;
  logic          unused_ok;

  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign unused_ok = ^{hresp, 32'(TO_CYCLES)};

  // a requester being acked this cycle is still holding req; ignore it
  assign cand      = req & ~ack;
  assign win       = cand[1] & (~cand[0] | ~last);
  assign win_oh    = win ? 2'b10 : 2'b01;
  assign own_oh    = own ? 2'b10 : 2'b01;
  assign win_addr  = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign win_size  = win ? req_size[5:3] : req_size[2:0];
  assign win_wdata = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign amask     = (AW'(1) << win_size) - AW'(1);
  assign misalign  = (win_size > MAXSZ) | (|(win_addr & amask));

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          to_n;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    last_n    = last;
    own_n     = own;
    wdata_n   = wdata_q;
    ack_n     = 2'b00;
    ack_err_n = 1'b0;
    rdata_n   = ack_rdata;
    gnt_n     = gnt;
    hsel_n    = hsel;
    haddr_n   = haddr;
    htrans_n  = htrans;
    hwrite_n  = hwrite;
    hsize_n   = hsize;
    hwdata_n  = hwdata;
`ifdef AHB_ARB_TIMEOUT_EN
    cnt_n     = '0;
    to_n      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|cand) begin
          last_n = win;
          if (misalign) begin
            ack_n     = win_oh;
            ack_err_n = 1'b1;
          end else begin
            state_n  = ADDR;
            own_n    = win;
            wdata_n  = win_wdata;
            gnt_n    = win_oh;
            hsel_n   = 1'b1;
            htrans_n = 2'b10;
            haddr_n  = win_addr;
            hwrite_n = req_write[win];
            hsize_n  = win_size;
          end
        end
      end
      ADDR: begin
        if (hready) begin
          state_n  = DATA;
          htrans_n = 2'b00;
          hsel_n   = 1'b0;
          hwdata_n = wdata_q;
        end
      end
      DATA: begin
        if (hready) begin
          if (!hwrite) rdata_n = hrdata;
          ack_n     = own_oh;
          ack_err_n = hresp[0];
          gnt_n     = 2'b00;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef AHB_ARB_TIMEOUT_EN
    if (state != IDLE && !hready) begin
      if (cnt == CW'(TO_CYCLES - 1)) begin
        ack_n     = own_oh;
        ack_err_n = 1'b1;
        to_n      = 1'b1;
        htrans_n  = 2'b00;
        hsel_n    = 1'b0;
        gnt_n     = 2'b00;
        state_n   = IDLE;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      last      <= 1'b1;
      own       <= 1'b0;
      wdata_q   <= '0;
      ack       <= 2'b00;
      ack_err   <= 1'b0;
      ack_rdata <= '0;
      gnt       <= 2'b00;
      hsel      <= 1'b0;
      haddr     <= '0;
      htrans    <= 2'b00;
      hwrite    <= 1'b0;
      hsize     <= 3'b000;
      hwdata    <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      own       <= own_n;
      wdata_q   <= wdata_n;
      ack       <= ack_n;
      ack_err   <= ack_err_n;
      ack_rdata <= rdata_n;
      gnt       <= gnt_n;
      hsel      <= hsel_n;
      haddr     <= haddr_n;
      htrans    <= htrans_n;
      hwrite    <= hwrite_n;
      hsize     <= hsize_n;
      hwdata    <= hwdata_n;
    end
  end

`ifdef AHB_ARB_TIMEOUT_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      timeout <= to_n;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Scoreboarded bench for ahb_lite_arbiter with a simple AHB slave model.
// Build with AHB_ARB_TIMEOUT_EN defined to cover the watchdog path.
module tb_ahb_lite_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 2;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [1:0]      req;
  logic [2*AW-1:0] req_addr;
  logic [1:0]      req_write;
  logic [5:0]      req_size;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      ack;
  logic            ack_err;
  logic [DW-1:0]   ack_rdata;
  logic [1:0]      gnt;
  logic            timeout;
  logic            hsel;
  logic [AW-1:0]   haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [2:0]      hburst;
  logic [3:0]      hprot;
  logic [DW-1:0]   hwdata;
  logic [DW-1:0]   hrdata;
  logic            hready;
  logic [RW-1:0]   hresp;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ack = 0;
  int          n_ack0;
  logic        use_ovr;
  logic [31:0] ovr_data;
  logic [31:0] dp_addr = '0;

  ahb_lite_arbiter #(.AW(AW), .DW(DW), .RW(RW), .TO_CYCLES(16)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_size(req_size), .req_wdata(req_wdata),
    .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata),
    .gnt(gnt), .timeout(timeout),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // slave returns a tag of the address captured in the address phase
  always @(posedge hclk)
    if (hsel && htrans == 2'b10 && hready) dp_addr <= haddr;
  assign hrdata = use_ovr ? ovr_data : {8'hD0, dp_addr[23:0]};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void expect_ack(logic [1:0] a, logic err, logic rd,
                                     logic [31:0] d);
    exp_t e;
    e.ack = a; e.err = err; e.rd = rd; e.rdata = d;
    sb.push_back(e);
  endfunction

  task automatic set_cmd(input int i, input logic [31:0] addr,
                         input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd);
    req_addr[i*AW +: AW]  = addr;
    req_write[i]          = wr;
    req_size[i*3 +: 3]    = sz;
    req_wdata[i*DW +: DW] = wd;
    req[i]                = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int max);
    int k;
    k = 0;
    while (ack == 2'b00 && k < max) begin
      @(negedge hclk);
      k++;
    end
    check(tag, ack != 2'b00, 1'b1);
  endtask

  always @(negedge hclk) begin
    if (hresetn === 1'b1 && ack !== 2'b00) begin
      n_ack++;
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", ack, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("sb_ack", ack, mon_e.ack);
        check("sb_err", ack_err, mon_e.err);
        if (mon_e.rd) check("sb_rdata", ack_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    req = '0; req_addr = '0; req_write = '0; req_size = '0; req_wdata = '0;
    hready = 1'b1; hresp = '0; use_ovr = 1'b0; ovr_data = '0;
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    check("rst_htrans", htrans, 2'b00);
    check("rst_hsel", hsel, 1'b0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", hwrite, 1'b0);
    check("rst_hsize", hsize, 3'b000);
    check("rst_hburst", hburst, 3'b000);
    check("rst_hprot", hprot, 4'b0011);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_ack", ack, 2'b00);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rdata", ack_rdata, 32'h0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_timeout", timeout, 1'b0);
    hresetn = 1'b1;
    @(negedge hclk);

    // single write, minimum latency
    set_cmd(0, 32'h10, 1'b1, 3'd2, 32'hA5A5_0001);
    expect_ack(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge hclk);
    check("t1_htrans", htrans, 2'b10);
    check("t1_hsel", hsel, 1'b1);
    check("t1_haddr", haddr, 32'h10);
    check("t1_hwrite", hwrite, 1'b1);
    check("t1_gnt", gnt, 2'b01);
    @(negedge hclk);
    check("t1_htrans_idle", htrans, 2'b00);
    check("t1_hwdata", hwdata, 32'hA5A5_0001);
    @(negedge hclk);
    check("t1_ack", ack, 2'b01);
    req[0] = 1'b0;
    @(negedge hclk);
    check("t1_ack_pulse", ack, 2'b00);
    check("t1_gnt_idle", gnt, 2'b00);

    // both requesters from reset, two reads each
    hresetn = 1'b0;
    set_cmd(0, 32'h100, 1'b0, 3'd2, 32'h0);
    set_cmd(1, 32'h200, 1'b0, 3'd2, 32'h0);
    expect_ack(2'b01, 1'b0, 1'b1, 32'hD000_0100);
    expect_ack(2'b10, 1'b0, 1'b1, 32'hD000_0200);
    expect_ack(2'b01, 1'b0, 1'b1, 32'hD000_0104);
    expect_ack(2'b10, 1'b0, 1'b1, 32'hD000_0204);
    @(negedge hclk);
    hresetn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bit seen_g;
      int k;
      seen_g = 1'b0;
      k = 0;
      do begin
        @(negedge hclk);
        k++;
        if (!seen_g && gnt != 2'b00) begin
          check("t2_gnt", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
          seen_g = 1'b1;
        end
      end while (ack == 2'b00 && k < 12);
      check("t2_done", ack != 2'b00, 1'b1);
      if (ack[0]) begin
        if (t < 2) req_addr[31:0] = 32'h104;
        else req[0] = 1'b0;
      end
      if (ack[1]) begin
        if (t < 2) req_addr[63:32] = 32'h204;
        else req[1] = 1'b0;
      end
    end
    req = 2'b00;
    @(negedge hclk);

    // read with three address-phase wait states
    use_ovr = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    set_cmd(0, 32'h20, 1'b0, 3'd2, 32'h0);
    expect_ack(2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge hclk);
    check("t3_nonseq", htrans, 2'b10);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check("t3_haddr_hold", haddr, 32'h20);
      check("t3_htrans_hold", htrans, 2'b10);
    end
    hready = 1'b1;
    wait_ack("t3_done", 6);
    check("t3_rdata", ack_rdata, 32'hDEAD_BEEF);
    req[0] = 1'b0;
    use_ovr = 1'b0;
    @(negedge hclk);

    // two-cycle ERROR response on a write
    set_cmd(0, 32'h30, 1'b1, 3'd2, 32'h1234_5678);
    expect_ack(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge hclk);
    check("t4_nonseq", htrans, 2'b10);
    @(negedge hclk);
    check("t4_hwdata", hwdata, 32'h1234_5678);
    hready = 1'b0;
    hresp = 2'b01;
    @(negedge hclk);
    check("t4_no_ack_yet", ack, 2'b00);
    check("t4_hwdata_hold", hwdata, 32'h1234_5678);
    hready = 1'b1;
    @(negedge hclk);
    check("t4_ack", ack, 2'b01);
    check("t4_err", ack_err, 1'b1);
    hresp = 2'b00;
    req[0] = 1'b0;
    @(negedge hclk);

    // misaligned address, then oversize, then aligned halfword
    set_cmd(1, 32'h2, 1'b0, 3'd2, 32'h0);
    expect_ack(2'b10, 1'b1, 1'b0, 32'h0);
    @(negedge hclk);
    check("t5_ack", ack, 2'b10);
    check("t5_htrans", htrans, 2'b00);
    check("t5_gnt", gnt, 2'b00);
    req[1] = 1'b0;
    @(negedge hclk);
    check("t5_no_bus", htrans, 2'b00);
    set_cmd(0, 32'h8, 1'b0, 3'd3, 32'h0);
    expect_ack(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge hclk);
    check("t5_size_ack", ack, 2'b01);
    check("t5_size_htrans", htrans, 2'b00);
    req[0] = 1'b0;
    @(negedge hclk);
    set_cmd(1, 32'h6, 1'b0, 3'd1, 32'h0);
    expect_ack(2'b10, 1'b0, 1'b1, 32'hD000_0006);
    @(negedge hclk);
    check("t5_half_htrans", htrans, 2'b10);
    check("t5_half_hsize", hsize, 3'd1);
    wait_ack("t5_half_done", 6);
    req[1] = 1'b0;
    @(negedge hclk);

    // long data-phase stall
    set_cmd(0, 32'h40, 1'b0, 3'd2, 32'h0);
`ifdef AHB_ARB_TIMEOUT_EN
    expect_ack(2'b01, 1'b1, 1'b0, 32'h0);
`else
    expect_ack(2'b01, 1'b0, 1'b1, 32'hD000_0040);
`endif
    @(negedge hclk);
    @(negedge hclk);
    hready = 1'b0;
    repeat (15) @(negedge hclk);
    check("t6_no_to_early", timeout, 1'b0);
    check("t6_no_ack_early", ack, 2'b00);
    @(negedge hclk);
`ifdef AHB_ARB_TIMEOUT_EN
    check("t6_timeout", timeout, 1'b1);
    check("t6_to_ack", ack, 2'b01);
    check("t6_to_err", ack_err, 1'b1);
    check("t6_to_htrans", htrans, 2'b00);
    check("t6_to_gnt", gnt, 2'b00);
    hready = 1'b1;
    req[0] = 1'b0;
    @(negedge hclk);
    check("t6_to_pulse", timeout, 1'b0);
`else
    check("t6_wait_to", timeout, 1'b0);
    check("t6_wait_ack", ack, 2'b00);
    check("t6_wait_gnt", gnt, 2'b01);
    repeat (4) @(negedge hclk);
    check("t6_still_wait", ack, 2'b00);
    hready = 1'b1;
    wait_ack("t6_done", 4);
    req[0] = 1'b0;
`endif
    @(negedge hclk);

    // async reset in the middle of a stalled transfer
    n_ack0 = n_ack;
    set_cmd(1, 32'h50, 1'b1, 3'd2, 32'h5555_AAAA);
    @(negedge hclk);
    @(negedge hclk);
    hready = 1'b0;
    repeat (5) @(negedge hclk);
    check("t7_gnt_busy", gnt, 2'b10);
    #2 hresetn = 1'b0;
    #1;
    check("t7_rst_gnt", gnt, 2'b00);
    check("t7_rst_htrans", htrans, 2'b00);
    check("t7_rst_hwdata", hwdata, 32'h0);
    check("t7_rst_ack", ack, 2'b00);
    req = 2'b00;
    hready = 1'b1;
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (20) @(negedge hclk);
    check("t7_no_ack", n_ack, n_ack0);
    check("t7_idle", htrans, 2'b00);

    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
